// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch stage: next-PC selection, imem req/ack
// handshake and a two-entry (output + skid) buffer toward decode.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FULL
    } state_t;

    state_t      state_q, state_d;
    logic        armed_q, armed_d;
    logic        req_q, req_d;
    logic        drop_q, drop_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic        redirect;
    logic        consume;
    logic        accept;
    logic [31:0] pc_plus4;
    logic [31:0] target;

    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        redirect = jump | branch;
        if (jump) begin
            target = {pc_plus4[31:28], jump_index, 2'b00};
        end else begin
            target = branch_target & 32'hFFFF_FFFC;
        end
        consume = out_valid_q & ~stall;
        accept  = req_q & imem_ack & ~drop_q & ~redirect;
    end

    always_comb begin
        state_d      = state_q;
        armed_d      = 1'b1;
        drop_d       = drop_q;
        pc_d         = pc_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (consume) begin
            if (skid_valid_q) begin
                out_instr_d  = skid_instr_q;
                out_pc_d     = skid_pc_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        if (accept) begin
            pc_d = pc_plus4;
            if ((!out_valid_q || consume) && !skid_valid_q) begin
                out_valid_d = 1'b1;
                out_instr_d = imem_rdata;
                out_pc_d    = pc_q;
            end else begin
                skid_valid_d = 1'b1;
                skid_instr_d = imem_rdata;
                skid_pc_d    = pc_q;
            end
        end

        // Any ack retires the outstanding request, including one marked for discard.
        if (req_q && imem_ack) begin
            drop_d = 1'b0;
        end

        if (redirect) begin
            pc_d         = target;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            if (req_q && !imem_ack) begin
                drop_d = 1'b1;
            end
        end

        // The abandoned request keeps its address on the bus until its ack arrives.
        addr_d = drop_d ? addr_q : pc_d;

        case (state_q)
            IDLE:    if (armed_q) state_d = FETCH;
            FETCH:   if (skid_valid_d) state_d = FULL;
            FULL:    if (!skid_valid_d) state_d = FETCH;
            default: state_d = IDLE;
        endcase

        req_d = (state_d == FETCH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            armed_q      <= 1'b0;
            req_q        <= 1'b0;
            drop_q       <= 1'b0;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            out_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            req_q        <= req_d;
            drop_q       <= drop_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = out_valid_q;
    assign instr       = out_instr_q;
    assign instr_pc    = out_pc_q;

    a_req_hold: assert property (@(posedge clk) disable iff (!reset)
        (req_q && !imem_ack) |=> (req_q && $stable(addr_q)));
    a_skid_order: assert property (@(posedge clk) disable iff (!reset)
        skid_valid_q |-> out_valid_q);
    a_pc_align: assert property (@(posedge clk) disable iff (!reset)
        pc_q[1:0] == 2'b00);

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: queue-based reference model of the fetch buffer, driven by
// scripted and random memory/decode behaviour.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch, jump, stall, imem_ack;
    logic [31:0] branch_target, imem_rdata;
    logic [25:0] jump_index;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, instr_pc;

    logic        w_reset;
    logic        w_zero;
    logic [31:0] w_zero32;
    logic [25:0] w_zero26;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc;

    int errors = 0;
    int checks = 0;

    pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .branch(branch), .branch_target(branch_target),
        .jump(jump), .jump_index(jump_index), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc)
    );

    pc_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(w_reset), .branch(w_zero), .branch_target(w_zero32),
        .jump(w_zero), .jump_index(w_zero26), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata), .stall(w_zero),
        .instr_valid(w_valid), .instr(w_instr), .instr_pc(w_pc)
    );

    assign w_rdata = w_addr ^ 32'hA5A5_0000;

    always #5 clk = ~clk;

    // Reference model: a FIFO of at most two delivered words plus the fetch PC.
    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } entry_t;

    entry_t      m_q[$];
    logic [31:0] m_pc, m_hold;
    bit          m_drop, m_req;
    int          m_edges;

    function automatic logic [31:0] m_addr();
        return m_drop ? m_hold : m_pc;
    endfunction

    task automatic model_reset();
        m_pc    = 32'h0;
        m_hold  = 32'h0;
        m_drop  = 1'b0;
        m_req   = 1'b0;
        m_edges = 0;
        m_q.delete();
    endtask

    task automatic model_step();
        logic [31:0] a, pc4, tgt;
        entry_t      e;
        a   = m_addr();
        pc4 = m_pc + 32'd4;
        tgt = jump ? {pc4[31:28], jump_index, 2'b00} : {branch_target[31:2], 2'b00};
        if (m_q.size() != 0 && !stall) void'(m_q.pop_front());
        if (m_req && imem_ack) begin
            if (m_drop) begin
                m_drop = 1'b0;
            end else if (!(jump || branch)) begin
                e.ins = imem_rdata;
                e.pc  = m_pc;
                m_q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        if (jump || branch) begin
            if (m_req && !imem_ack) begin
                if (!m_drop) m_hold = a;
                m_drop = 1'b1;
            end
            m_q.delete();
            m_pc = tgt;
        end
        if (m_edges < 2) m_edges++;
        m_req = (m_edges >= 2) && (m_q.size() < 2);
    endtask

    task automatic drive_idle();
        branch = 0; jump = 0; stall = 0; imem_ack = 0;
        branch_target = '0; jump_index = '0; imem_rdata = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        drive_idle();
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        int first;
        reset = 1'b0;
        drive_idle();
        model_reset();
        @(posedge clk); #2;
        checks++;
        if ({imem_req, imem_addr, instr_valid, instr, instr_pc} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_values got req=%b addr=%h vld=%b instr=%h pc=%h want all zero",
                     imem_req, imem_addr, instr_valid, instr, instr_pc);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        first = -1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({imem_req, imem_addr, instr_valid} !== {m_req, m_addr(), m_q.size() != 0}) begin
                errors++;
                $display("FAIL reset_ctl cyc=%0d got req=%b addr=%h vld=%b want req=%b addr=%h vld=%b",
                         c, imem_req, imem_addr, instr_valid, m_req, m_addr(), m_q.size() != 0);
            end
            if (imem_req && first < 0) first = c;
            model_step();
            @(posedge clk); #1;
        end
        checks++;
        if (first !== 2) begin
            errors++;
            $display("FAIL reset_first_req got cycle %0d want 2", first);
        end
    endtask

    task automatic test_streaming();
        apply_reset();
        for (int c = 0; c < 16; c++) begin
            imem_ack   = 1'b1;
            imem_rdata = m_addr() ^ 32'hA5A5_0000;
            @(negedge clk);
            checks++;
            if ({imem_req, imem_addr, instr_valid} !== {m_req, m_addr(), m_q.size() != 0}) begin
                errors++;
                $display("FAIL stream_ctl cyc=%0d got req=%b addr=%h vld=%b want req=%b addr=%h vld=%b",
                         c, imem_req, imem_addr, instr_valid, m_req, m_addr(), m_q.size() != 0);
            end
            if (m_q.size() != 0) begin
                checks++;
                if ({instr, instr_pc} !== {m_q[0].ins, m_q[0].pc}) begin
                    errors++;
                    $display("FAIL stream_data cyc=%0d got %h@%h want %h@%h",
                             c, instr, instr_pc, m_q[0].ins, m_q[0].pc);
                end
            end
            model_step();
            @(posedge clk); #1;
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr, instr_valid, instr, instr_pc} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL async_reset got req=%b addr=%h vld=%b instr=%h pc=%h want all zero",
                     imem_req, imem_addr, instr_valid, instr, instr_pc);
        end
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_wait_states();
        int          wcnt;
        bit          prev_hold;
        logic [31:0] prev_addr;
        apply_reset();
        wcnt = 0;
        prev_hold = 1'b0;
        prev_addr = '0;
        for (int c = 0; c < 40; c++) begin
            imem_ack   = m_req && (wcnt == 3);
            imem_rdata = m_addr() ^ 32'hA5A5_0000;
            @(negedge clk);
            checks++;
            if ({imem_req, imem_addr, instr_valid} !== {m_req, m_addr(), m_q.size() != 0}) begin
                errors++;
                $display("FAIL wait_ctl cyc=%0d got req=%b addr=%h vld=%b want req=%b addr=%h vld=%b",
                         c, imem_req, imem_addr, instr_valid, m_req, m_addr(), m_q.size() != 0);
            end
            if (m_q.size() != 0) begin
                checks++;
                if ({instr, instr_pc} !== {m_q[0].ins, m_q[0].pc}) begin
                    errors++;
                    $display("FAIL wait_data cyc=%0d got %h@%h want %h@%h",
                             c, instr, instr_pc, m_q[0].ins, m_q[0].pc);
                end
            end
            if (prev_hold) begin
                checks++;
                if ({imem_req, imem_addr} !== {1'b1, prev_addr}) begin
                    errors++;
                    $display("FAIL wait_hold cyc=%0d got req=%b addr=%h want req=1 addr=%h",
                             c, imem_req, imem_addr, prev_addr);
                end
            end
            prev_hold = m_req && !imem_ack;
            prev_addr = m_addr();
            if (m_req) wcnt = imem_ack ? 0 : wcnt + 1;
            model_step();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc;
        apply_reset();
        exp_pc = 32'h0;
        for (int c = 0; c < 20; c++) begin
            imem_ack   = 1'b1;
            stall      = (c >= 4 && c < 9);
            imem_rdata = m_addr() ^ 32'hA5A5_0000;
            @(negedge clk);
            checks++;
            if ({imem_req, imem_addr, instr_valid} !== {m_req, m_addr(), m_q.size() != 0}) begin
                errors++;
                $display("FAIL stall_ctl cyc=%0d got req=%b addr=%h vld=%b want req=%b addr=%h vld=%b",
                         c, imem_req, imem_addr, instr_valid, m_req, m_addr(), m_q.size() != 0);
            end
            if (m_q.size() != 0) begin
                checks++;
                if ({instr, instr_pc} !== {m_q[0].ins, m_q[0].pc}) begin
                    errors++;
                    $display("FAIL stall_data cyc=%0d got %h@%h want %h@%h",
                             c, instr, instr_pc, m_q[0].ins, m_q[0].pc);
                end
            end
            if (c >= 5 && c < 9) begin
                checks++;
                if (imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_req_drop cyc=%0d got req=%b want 0", c, imem_req);
                end
            end
            if (instr_valid === 1'b1 && !stall) begin
                checks++;
                if (instr_pc !== exp_pc) begin
                    errors++;
                    $display("FAIL stall_order cyc=%0d got pc=%h want %h", c, instr_pc, exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
            end
            model_step();
            @(posedge clk); #1;
        end
        stall = 1'b0;
    endtask

    task automatic test_redirect_outstanding();
        bit reached;
        apply_reset();
        reached = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (m_req && m_addr() == 32'h10) begin
                reached = 1'b1;
                break;
            end
            imem_ack   = 1'b1;
            imem_rdata = m_addr() ^ 32'hA5A5_0000;
            @(negedge clk);
            checks++;
            if ({imem_req, imem_addr, instr_valid} !== {m_req, m_addr(), m_q.size() != 0}) begin
                errors++;
                $display("FAIL redir_pre cyc=%0d got req=%b addr=%h vld=%b want req=%b addr=%h vld=%b",
                         c, imem_req, imem_addr, instr_valid, m_req, m_addr(), m_q.size() != 0);
            end
            model_step();
            @(posedge clk); #1;
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL redir_reach got no request at 00000010 within 20 cycles want one");
        end
        for (int c = 0; c < 8; c++) begin
            imem_ack      = (c >= 2);
            branch        = (c == 0);
            branch_target = 32'h0000_0040;
            imem_rdata    = m_addr() ^ 32'hA5A5_0000;
            @(negedge clk);
            checks++;
            if ({imem_req, imem_addr, instr_valid} !== {m_req, m_addr(), m_q.size() != 0}) begin
                errors++;
                $display("FAIL redir_ctl cyc=%0d got req=%b addr=%h vld=%b want req=%b addr=%h vld=%b",
                         c, imem_req, imem_addr, instr_valid, m_req, m_addr(), m_q.size() != 0);
            end
            if (c == 3) begin
                checks++;
                if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h0000_0040, 1'b0}) begin
                    errors++;
                    $display("FAIL redir_target got req=%b addr=%h vld=%b want req=1 addr=00000040 vld=0",
                             imem_req, imem_addr, instr_valid);
                end
            end
            if (c == 4) begin
                checks++;
                if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h0000_0040, 32'hA5A5_0040}) begin
                    errors++;
                    $display("FAIL redir_first got vld=%b pc=%h instr=%h want vld=1 pc=00000040 instr=a5a50040",
                             instr_valid, instr_pc, instr);
                end
            end
            model_step();
            @(posedge clk); #1;
        end
        branch = 1'b0;
    endtask

    task automatic test_jump_priority();
        for (int c = 0; c < 8; c++) begin
            imem_ack      = 1'b1;
            branch        = (c == 0 || c == 3);
            jump          = (c == 3);
            branch_target = (c == 0) ? 32'h8000_00F8 : 32'h0000_1230;
            jump_index    = 26'h000_0040;
            stall         = (c >= 1 && c <= 4);
            imem_rdata    = m_addr() ^ 32'hA5A5_0000;
            @(negedge clk);
            checks++;
            if ({imem_req, imem_addr, instr_valid} !== {m_req, m_addr(), m_q.size() != 0}) begin
                errors++;
                $display("FAIL jump_ctl cyc=%0d got req=%b addr=%h vld=%b want req=%b addr=%h vld=%b",
                         c, imem_req, imem_addr, instr_valid, m_req, m_addr(), m_q.size() != 0);
            end
            if (c == 3) begin
                checks++;
                if ({imem_req, instr_valid, instr_pc} !== {1'b0, 1'b1, 32'h8000_00F8}) begin
                    errors++;
                    $display("FAIL jump_prefill got req=%b vld=%b pc=%h want req=0 vld=1 pc=800000f8",
                             imem_req, instr_valid, instr_pc);
                end
            end
            if (c == 4) begin
                checks++;
                if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h8000_0100, 1'b0}) begin
                    errors++;
                    $display("FAIL jump_target got req=%b addr=%h vld=%b want req=1 addr=80000100 vld=0",
                             imem_req, imem_addr, instr_valid);
                end
            end
            model_step();
            @(posedge clk); #1;
        end
        drive_idle();
    endtask

    task automatic test_random();
        int unsigned r;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            r             = $urandom_range(0, 19);
            jump          = (r == 0);
            branch        = (r <= 1);
            branch_target = $urandom;
            jump_index    = 26'($urandom);
            imem_ack      = ($urandom_range(0, 3) != 0);
            stall         = ($urandom_range(0, 3) == 0);
            imem_rdata    = $urandom;
            @(negedge clk);
            checks++;
            if ({imem_req, imem_addr, instr_valid} !== {m_req, m_addr(), m_q.size() != 0}) begin
                errors++;
                $display("FAIL rand_ctl cyc=%0d got req=%b addr=%h vld=%b want req=%b addr=%h vld=%b",
                         c, imem_req, imem_addr, instr_valid, m_req, m_addr(), m_q.size() != 0);
            end
            if (m_q.size() != 0) begin
                checks++;
                if ({instr, instr_pc} !== {m_q[0].ins, m_q[0].pc}) begin
                    errors++;
                    $display("FAIL rand_data cyc=%0d got %h@%h want %h@%h",
                             c, instr, instr_pc, m_q[0].ins, m_q[0].pc);
                end
            end
            model_step();
            @(posedge clk); #1;
        end
        drive_idle();
    endtask

    task automatic test_wrap();
        bit found;
        w_ack = 1'b1;
        checks++;
        if ({w_req, w_addr, w_valid} !== {1'b0, 32'hFFFF_FFF8, 1'b0}) begin
            errors++;
            $display("FAIL wrap_reset got req=%b addr=%h vld=%b want req=0 addr=fffffff8 vld=0",
                     w_req, w_addr, w_valid);
        end
        @(posedge clk); #1;
        w_reset = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (w_req) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wrap_start got no request within 6 cycles want one");
        end
        checks++;
        if (w_addr !== 32'hFFFF_FFF8) begin
            errors++;
            $display("FAIL wrap_addr0 got %h want fffffff8", w_addr);
        end
        @(negedge clk);
        checks++;
        if ({w_addr, w_valid, w_pc, w_instr} !== {32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFF8, 32'h5A5A_FFF8}) begin
            errors++;
            $display("FAIL wrap_addr1 got addr=%h vld=%b pc=%h instr=%h want fffffffc 1 fffffff8 5a5afff8",
                     w_addr, w_valid, w_pc, w_instr);
        end
        @(negedge clk);
        checks++;
        if ({w_addr, w_valid, w_pc, w_instr} !== {32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 32'h5A5A_FFFC}) begin
            errors++;
            $display("FAIL wrap_addr2 got addr=%h vld=%b pc=%h instr=%h want 00000000 1 fffffffc 5a5afffc",
                     w_addr, w_valid, w_pc, w_instr);
        end
        @(posedge clk); #2;
        w_reset = 1'b0;
        #1;
        checks++;
        if ({w_req, w_addr, w_valid, w_instr, w_pc} !== {1'b0, 32'hFFFF_FFF8, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL wrap_async_reset got req=%b addr=%h vld=%b instr=%h pc=%h want 0 fffffff8 0 0 0",
                     w_req, w_addr, w_valid, w_instr, w_pc);
        end
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL timeout got no completion by 500000 ns want completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset    = 1'b0;
        w_reset  = 1'b0;
        w_zero   = 1'b0;
        w_zero32 = '0;
        w_zero26 = '0;
        w_ack    = 1'b0;
        drive_idle();
        test_reset();
        test_streaming();
        test_wait_states();
        test_stall();
        test_redirect_outstanding();
        test_jump_priority();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and instruction-fetch stage of the MIPS data path. Holds the PC register, computes the next PC (sequential, branch, jump), requests instructions from instruction memory over a req/ack handshake, and delivers {instruction, PC} to decode through a two-entry buffer (output register plus skid register) that honours a decode stall. It replaces the bare PC flip-flop at the head of the data path and feeds the IF/ID boundary.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- branch  in  1  redirect to branch_target this cycle
- branch_target  in  32  branch destination, word aligned
- jump  in  1  redirect to jump target this cycle; takes priority over branch
- jump_index  in  26  jump field; target = {pc_plus4[31:28], jump_index, 2'b00}, where pc_plus4 is the current PC register + 4
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, equal to the PC register
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  instruction word
- stall  in  1  decode cannot accept; hold instr/instr_pc
- instr_valid  out  1  instr/instr_pc valid
- instr  out  32  fetched instruction
- instr_pc  out  32  address of instr

## Operation
- States:
  - IDLE: one cycle after reset release.
  - FETCH: imem_req = 1.
  - FULL: the skid register is occupied; imem_req = 0.
- Transitions:
  - IDLE -> FETCH unconditionally.
  - FETCH -> FULL when imem_ack lands in the skid register.
  - FULL -> FETCH when the skid register drains.
- Handshake:
  - Once imem_req rises, it and imem_addr stay stable until the cycle imem_ack = 1.
  - imem_ack is ignored when imem_req = 0.
  - Back-to-back fetches are allowed: req stays high through consecutive acks.
- On an accepted ack (no redirect, no drop pending):
  - PC <= PC + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - If the output register is empty, or is being consumed this cycle (instr_valid & ~stall), {imem_rdata, PC} goes to the output register.
  - Otherwise it goes to the skid register.
- Consumption: when instr_valid & ~stall, the output register loads from the skid register if the skid is valid; otherwise it empties (unless filled by an ack the same cycle).
- Redirect (jump | branch):
  - PC <= target.
  - Output and skid valid bits clear in the same edge.
  - If a request is outstanding without ack in this cycle, drop_pending <= 1. The next ack is then discarded: no PC increment, no buffer write, drop_pending clears, and the target is requested next.
  - If the redirect coincides with imem_ack, that data is discarded and PC <= target.
  - jump and branch together: jump wins.
  - A redirect while stall = 1 still flushes; stall only gates consumption.
- Alignment: PC[1:0] always 00. A target with nonzero low bits has those bits forced to 0.

## Timing
- Reset values (async, while reset = 0):
  - PC = RESET_PC, state = IDLE, drop_pending = 0.
  - imem_req = 0, imem_addr = RESET_PC.
  - instr_valid = 0, instr = 0, instr_pc = 0, skid empty.
- First imem_req = 1 on the second rising edge after reset deasserts.
- Fetch latency: ack in cycle N gives instr_valid = 1 after edge N (visible in cycle N+1).
- Throughput: with ack held high and stall = 0, one instruction per cycle.
- Stall: instr/instr_pc/instr_valid are frozen while stall = 1. At most one further instruction is accepted (into the skid register), then imem_req drops the next cycle.
- Reset mid-transaction: abandons any outstanding request immediately; no drop state survives.
- Redirect: first request to the target appears the cycle after the redirect, or the cycle after the outstanding ack if drop_pending was set.

## Test plan
- Reset and streaming:
  - Stimulus: reset low 12 ns, then release; imem_ack tied 1; imem_rdata = address ^ 32'hA5A5_0000.
  - Response: imem_addr goes 0, 4, 8, …; instr_valid goes high one cycle after the first ack; instr_pc follows 0, 4, 8 with matching instr.
- Wait states:
  - Stimulus: ack delayed 3 cycles per request.
  - Response: imem_req and imem_addr are held stable across the wait; one instr per 4 cycles.
- Stall backpressure:
  - Stimulus: stall = 1 for 5 cycles with ack tied 1.
  - Response: instr frozen; skid captures exactly one word; imem_req = 0 after it. On release, the words come out in order with no loss or duplication.
- Redirect during outstanding request:
  - Stimulus: req pending at 0x10, ack withheld; branch = 1 with target 0x40; ack 2 cycles later.
  - Response: that ack's data is dropped; the next imem_addr = 0x40; instr_valid stays 0 until 0x40 returns.
- Redirect priority and jump arithmetic:
  - Stimulus: PC = 0x8000_0100, jump = 1 and branch = 1 together, jump_index = 26'h000_0040.
  - Response: next imem_addr = 0x8000_0100; the stalled output register and the skid register are flushed.
- Wrap and async reset:
  - Stimulus: RESET_PC = 32'hFFFF_FFF8 with ack tied 1; then assert reset mid-request.
  - Response: addresses go FFFF_FFF8, FFFF_FFFC, 0000_0000. On reset assertion, all outputs return to their reset values immediately, without waiting for a clock edge.
